// File: rtl/alu_pkg.sv
// Shared ALU encodings: ALUControl codes, RV32I opcode/funct3 constants, operand and taken selects.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_BNE  = 4'b1010;
  localparam logic [3:0] ALU_BLT  = 4'b1011;
  localparam logic [3:0] ALU_BGE  = 4'b1100;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {SRCA_RS1, SRCA_PC, SRCA_ZERO} src_a_sel_t;
  typedef enum logic {SRCB_RS2, SRCB_IMM} src_b_sel_t;
  typedef enum logic [1:0] {TK_ZERO, TK_CMP, TK_RES0, TK_NRES0} taken_sel_t;

  // alt selects SUB on 000 and SRA on 101; other funct3 values ignore it.
  function automatic logic [3:0] arith_code(input logic [2:0] f3, input logic alt);
    logic [3:0] code;
    case (f3)
      F3_ADD:  code = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  code = ALU_SLL;
      F3_SLT:  code = ALU_SLT;
      F3_SLTU: code = ALU_SLTU;
      F3_XOR:  code = ALU_XOR;
      F3_SR:   code = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational RV32I ALU: result, zero flag and comparison flag for one ALUControl code.
// Branch codes (BNE/BLT/BGE) return the comparison bit zero-extended as the result.
module alu
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            comparison
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  logic           lt;
  logic           ltu;
  logic           ne;

  assign shamt = src_b[SHW-1:0];
  assign lt    = $signed(src_a) < $signed(src_b);
  assign ltu   = src_a < src_b;
  assign ne    = src_a != src_b;

  always_comb begin
    result     = '0;
    comparison = 1'b0;
    case (alu_control)
      ALU_ADD:  result = src_a + src_b;
      ALU_SUB:  result = src_a - src_b;
      ALU_AND:  result = src_a & src_b;
      ALU_OR:   result = src_a | src_b;
      ALU_XOR:  result = src_a ^ src_b;
      ALU_SLT:  begin result = XLEN'(lt);  comparison = lt;  end
      ALU_SLTU: begin result = XLEN'(ltu); comparison = ltu; end
      ALU_SLL:  result = src_a << shamt;
      ALU_SRL:  result = src_a >> shamt;
      ALU_SRA:  result = $unsigned($signed(src_a) >>> shamt);
      ALU_BNE:  begin result = XLEN'(ne);  comparison = ne;  end
      ALU_BLT:  begin result = XLEN'(lt);  comparison = lt;  end
      ALU_BGE:  begin result = XLEN'(!lt); comparison = !lt; end
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_issue_ctrl_decoder.sv
// Stage-0 decode of opcode/funct3/funct7b5 into ALUControl, operand selects and branch resolution select.
// Purely combinational; illegal encodings yield ADD with zero operands and no branch.
module alu_decoder
  import alu_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  output logic [3:0]  alu_control,
  output src_a_sel_t  src_a_sel,
  output src_b_sel_t  src_b_sel,
  output logic        is_branch,
  output taken_sel_t  taken_sel,
  output logic        illegal
);

  always_comb begin
    alu_control = ALU_ADD;
    src_a_sel   = SRCA_ZERO;
    src_b_sel   = SRCB_RS2;
    is_branch   = 1'b0;
    taken_sel   = TK_ZERO;
    illegal     = 1'b0;
    case (opcode)
      OP_R: begin
        src_a_sel   = SRCA_RS1;
        alu_control = arith_code(funct3, funct7b5);
      end
      OP_I: begin
        src_a_sel   = SRCA_RS1;
        src_b_sel   = SRCB_IMM;
        // ADDI has no subtract form; only shifts look at imm[10].
        alu_control = arith_code(funct3, (funct3 == F3_SR) && funct7b5);
      end
      OP_LOAD, OP_STORE, OP_JALR: begin
        src_a_sel = SRCA_RS1;
        src_b_sel = SRCB_IMM;
      end
      OP_LUI: src_b_sel = SRCB_IMM;
      OP_AUIPC: begin
        src_a_sel = SRCA_PC;
        src_b_sel = SRCB_IMM;
      end
      OP_BRANCH: begin
        src_a_sel = SRCA_RS1;
        is_branch = 1'b1;
        case (funct3)
          F3_BEQ:  begin alu_control = ALU_SUB;  taken_sel = TK_ZERO;  end
          F3_BNE:  begin alu_control = ALU_BNE;  taken_sel = TK_CMP;   end
          F3_BLT:  begin alu_control = ALU_BLT;  taken_sel = TK_CMP;   end
          F3_BGE:  begin alu_control = ALU_BGE;  taken_sel = TK_CMP;   end
          F3_BLTU: begin alu_control = ALU_SLTU; taken_sel = TK_RES0;  end
          F3_BGEU: begin alu_control = ALU_SLTU; taken_sel = TK_NRES0; end
          default: begin
            src_a_sel = SRCA_ZERO;
            is_branch = 1'b0;
            illegal   = 1'b1;
          end
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage ALU front end: issue register drives the ALU, result register captures it; 2-cycle latency.
// Valid/ready on both sides, holds up to 2 instructions under backpressure, 1 instr/cycle when unstalled.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7b5,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc,
  output logic [3:0]      alu_control,
  output logic [XLEN-1:0] alu_src_a,
  output logic [XLEN-1:0] alu_src_b,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  input  logic            alu_comparison,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_is_branch,
  output logic            out_branch_taken,
  output logic            out_illegal
);

  logic [3:0]      dec_control;
  src_a_sel_t      dec_a_sel;
  src_b_sel_t      dec_b_sel;
  logic            dec_is_branch;
  taken_sel_t      dec_taken_sel;
  logic            dec_illegal;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;

  logic            issue_valid;
  logic            issue_is_branch;
  taken_sel_t      issue_taken_sel;
  logic            issue_illegal;

  logic            accept;
  logic            result_advance;
  logic            taken_bit;

  alu_decoder u_decoder (
    .opcode      (in_opcode),
    .funct3      (in_funct3),
    .funct7b5    (in_funct7b5),
    .alu_control (dec_control),
    .src_a_sel   (dec_a_sel),
    .src_b_sel   (dec_b_sel),
    .is_branch   (dec_is_branch),
    .taken_sel   (dec_taken_sel),
    .illegal     (dec_illegal)
  );

  always_comb begin
    op_a = '0;
    op_b = '0;
    case (dec_a_sel)
      SRCA_RS1: op_a = in_rs1;
      SRCA_PC:  op_a = in_pc;
      default:  op_a = '0;
    endcase
    if (!dec_illegal) begin
      op_b = (dec_b_sel == SRCB_IMM) ? in_imm : in_rs2;
    end
  end

  assign result_advance = issue_valid && (!out_valid || out_ready);
  assign in_ready       = !issue_valid || result_advance;
  assign accept         = in_valid && in_ready;

  always_comb begin
    taken_bit = 1'b0;
    case (issue_taken_sel)
      TK_ZERO:  taken_bit = alu_zero;
      TK_CMP:   taken_bit = alu_comparison;
      TK_RES0:  taken_bit = alu_result[0];
      TK_NRES0: taken_bit = ~alu_result[0];
      default:  taken_bit = 1'b0;
    endcase
  end

  // Issue register outputs fall back to ADD/0/0 whenever the stage empties.
  always_ff @(posedge clk) begin
    if (reset) begin
      issue_valid     <= 1'b0;
      alu_control     <= ALU_ADD;
      alu_src_a       <= '0;
      alu_src_b       <= '0;
      issue_is_branch <= 1'b0;
      issue_taken_sel <= TK_ZERO;
      issue_illegal   <= 1'b0;
    end else if (accept) begin
      issue_valid     <= 1'b1;
      alu_control     <= dec_control;
      alu_src_a       <= op_a;
      alu_src_b       <= op_b;
      issue_is_branch <= dec_is_branch;
      issue_taken_sel <= dec_taken_sel;
      issue_illegal   <= dec_illegal;
    end else if (result_advance) begin
      issue_valid     <= 1'b0;
      alu_control     <= ALU_ADD;
      alu_src_a       <= '0;
      alu_src_b       <= '0;
      issue_is_branch <= 1'b0;
      issue_taken_sel <= TK_ZERO;
      issue_illegal   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid        <= 1'b0;
      out_result       <= '0;
      out_is_branch    <= 1'b0;
      out_branch_taken <= 1'b0;
      out_illegal      <= 1'b0;
    end else if (result_advance) begin
      out_valid        <= 1'b1;
      out_result       <= issue_illegal ? '0 : alu_result;
      out_is_branch    <= issue_is_branch;
      out_branch_taken <= issue_is_branch && taken_bit;
      out_illegal      <= issue_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl driving the real alu; directed cases plus a randomized scoreboard run.
module tb_alu_issue_ctrl;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [6:0]      in_opcode;
  logic [2:0]      in_funct3;
  logic            in_funct7b5;
  logic [XLEN-1:0] in_rs1, in_rs2, in_imm, in_pc;
  logic [3:0]      alu_control;
  logic [XLEN-1:0] alu_src_a, alu_src_b, alu_result;
  logic            alu_zero, alu_comparison;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] out_result;
  logic            out_is_branch, out_branch_taken, out_illegal;

  int nchecks = 0;
  int nerr    = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_pc(in_pc),
    .alu_control(alu_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_comparison(alu_comparison),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_is_branch(out_is_branch), .out_branch_taken(out_branch_taken), .out_illegal(out_illegal)
  );

  alu #(.XLEN(XLEN)) u_alu (
    .alu_control(alu_control), .src_a(alu_src_a), .src_b(alu_src_b),
    .result(alu_result), .zero(alu_zero), .comparison(alu_comparison)
  );

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] rs1, rs2, imm, pc;
  } instr_t;

  typedef struct packed {
    logic [31:0] res;
    logic        br;
    logic        tk;
    logic        ill;
  } exp_t;

  // Architectural meaning of each instruction, straight from RV32I semantics.
  function automatic exp_t model(instr_t i);
    exp_t        e;
    logic [31:0] b;
    logic        lt, ltu;
    e = '0;
    case (i.op)
      7'b0110011, 7'b0010011: begin
        b = (i.op == 7'b0110011) ? i.rs2 : i.imm;
        case (i.f3)
          3'd0: e.res = (i.op == 7'b0110011 && i.f7) ? i.rs1 - b : i.rs1 + b;
          3'd1: e.res = i.rs1 << b[4:0];
          3'd2: e.res = ($signed(i.rs1) < $signed(b)) ? 32'd1 : 32'd0;
          3'd3: e.res = (i.rs1 < b) ? 32'd1 : 32'd0;
          3'd4: e.res = i.rs1 ^ b;
          3'd5: e.res = i.f7 ? $unsigned($signed(i.rs1) >>> b[4:0]) : i.rs1 >> b[4:0];
          3'd6: e.res = i.rs1 | b;
          default: e.res = i.rs1 & b;
        endcase
      end
      7'b0000011, 7'b0100011, 7'b1100111: e.res = i.rs1 + i.imm;
      7'b0110111: e.res = i.imm;
      7'b0010111: e.res = i.pc + i.imm;
      7'b1100011: begin
        lt   = $signed(i.rs1) < $signed(i.rs2);
        ltu  = i.rs1 < i.rs2;
        e.br = 1'b1;
        case (i.f3)
          3'd0: begin e.res = i.rs1 - i.rs2; e.tk = (i.rs1 == i.rs2); end
          3'd1: begin e.tk = (i.rs1 != i.rs2); e.res = {31'd0, e.tk}; end
          3'd4: begin e.tk = lt;  e.res = {31'd0, lt};  end
          3'd5: begin e.tk = !lt; e.res = {31'd0, !lt}; end
          3'd6: begin e.tk = ltu; e.res = {31'd0, ltu}; end
          3'd7: begin e.tk = !ltu; e.res = {31'd0, ltu}; end
          default: begin e.br = 1'b0; e.ill = 1'b1; end
        endcase
      end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic drive(instr_t i);
    in_opcode = i.op; in_funct3 = i.f3; in_funct7b5 = i.f7;
    in_rs1 = i.rs1; in_rs2 = i.rs2; in_imm = i.imm; in_pc = i.pc;
  endtask

  function automatic instr_t mk(logic [6:0] op, logic [2:0] f3, logic f7,
                                logic [31:0] rs1, logic [31:0] rs2, logic [31:0] imm, logic [31:0] pc);
    instr_t i;
    i.op = op; i.f3 = f3; i.f7 = f7; i.rs1 = rs1; i.rs2 = rs2; i.imm = imm; i.pc = pc;
    return i;
  endfunction

  task automatic check_idle(string tag);
    nchecks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      nerr++; $display("FAIL %s handshake: out_valid/in_ready=%b required 01", tag, {out_valid, in_ready});
    end
    nchecks++;
    if ({alu_control, alu_src_a, alu_src_b} !== '0) begin
      nerr++; $display("FAIL %s issue outs: ctrl=%h a=%h b=%h required 0/0/0", tag, alu_control, alu_src_a, alu_src_b);
    end
    nchecks++;
    if ({out_result, out_is_branch, out_branch_taken, out_illegal} !== '0) begin
      nerr++; $display("FAIL %s result outs: res=%h br=%b tk=%b ill=%b required all 0", tag,
                       out_result, out_is_branch, out_branch_taken, out_illegal);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    drive(mk(7'b0110011, 3'd0, 1'b0, 32'd3, 32'd4, 32'd0, 32'd0));
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0; in_valid = 1'b0; #1;
    check_idle("reset");
  endtask

  task automatic run_one(string tag, instr_t i, logic [3:0] ectrl, logic [31:0] ea,
                         logic [31:0] eres, logic ebr, logic etk, logic eill);
    @(negedge clk);
    drive(i); in_valid = 1'b1; out_ready = 1'b1; #1;
    nchecks++;
    if (in_ready !== 1'b1) begin nerr++; $display("FAIL %s in_ready: %b required 1", tag, in_ready); end
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0; #1;
    nchecks++;
    if (alu_control !== ectrl) begin nerr++; $display("FAIL %s alu_control: %b required %b", tag, alu_control, ectrl); end
    nchecks++;
    if (alu_src_a !== ea) begin nerr++; $display("FAIL %s alu_src_a: %h required %h", tag, alu_src_a, ea); end
    nchecks++;
    if (out_valid !== 1'b0) begin nerr++; $display("FAIL %s early out_valid: %b required 0", tag, out_valid); end
    @(posedge clk);
    @(negedge clk); #1;
    nchecks++;
    if (out_valid !== 1'b1) begin nerr++; $display("FAIL %s out_valid: %b required 1", tag, out_valid); end
    nchecks++;
    if ({out_result, out_is_branch, out_branch_taken, out_illegal} !== {eres, ebr, etk, eill}) begin
      nerr++; $display("FAIL %s result: res=%h br=%b tk=%b ill=%b required res=%h br=%b tk=%b ill=%b", tag,
                       out_result, out_is_branch, out_branch_taken, out_illegal, eres, ebr, etk, eill);
    end
    @(posedge clk);
  endtask

  task automatic test_directed();
    run_one("r_sub",  mk(7'b0110011, 3'd0, 1'b1, 32'd10, 32'd5, 32'd0, 32'd0), 4'b0001, 32'd10, 32'd5, 0, 0, 0);
    run_one("i_sra",  mk(7'b0010011, 3'd5, 1'b1, 32'hFFFFFFF0, 32'd0, 32'd2, 32'd0), 4'b1001, 32'hFFFFFFF0,
            32'hFFFFFFFC, 0, 0, 0);
    run_one("beq",    mk(7'b1100011, 3'd0, 1'b0, 32'd7, 32'd7, 32'd0, 32'd0), 4'b0001, 32'd7, 32'd0, 1, 1, 0);
    run_one("bgeu",   mk(7'b1100011, 3'd7, 1'b0, 32'd1, 32'hFFFFFFFF, 32'd0, 32'd0), 4'b0110, 32'd1, 32'd1, 1, 0, 0);
    run_one("blt",    mk(7'b1100011, 3'd4, 1'b0, 32'd0, 32'd1, 32'd0, 32'd0), 4'b1011, 32'd0, 32'd1, 1, 1, 0);
    run_one("lui",    mk(7'b0110111, 3'd0, 1'b0, 32'hDEADBEEF, 32'd0, 32'h12345000, 32'd0), 4'b0000, 32'd0,
            32'h12345000, 0, 0, 0);
    run_one("auipc",  mk(7'b0010111, 3'd0, 1'b0, 32'hDEADBEEF, 32'd0, 32'h1000, 32'h100), 4'b0000, 32'h100,
            32'h1100, 0, 0, 0);
    run_one("illegal", mk(7'b1111111, 3'd0, 1'b0, 32'h55, 32'h66, 32'h77, 32'h88), 4'b0000, 32'd0, 32'd0, 0, 0, 1);
    run_one("br_f3_2", mk(7'b1100011, 3'd2, 1'b0, 32'd9, 32'd9, 32'd0, 32'd0), 4'b0000, 32'd0, 32'd0, 0, 0, 1);
  endtask

  task automatic test_back_to_back();
    int          idx = 0;
    int          first = -1;
    int          last = -1;
    logic [31:0] held;
    logic        have_held = 1'b0;
    logic [31:0] got[$];
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      in_valid  = (idx < 4);
      drive(mk(7'b0110011, 3'd0, 1'b0, idx + 1, 32'd0, 32'd0, 32'd0));
      #1;
      if (cyc >= 2 && cyc < 5) begin
        nchecks++;
        if (in_ready !== 1'b0 || idx != 2) begin
          nerr++; $display("FAIL bp_full cyc%0d: in_ready=%b accepts=%0d required 0 and 2", cyc, in_ready, idx);
        end
        if (have_held) begin
          nchecks++;
          if (out_valid !== 1'b1 || out_result !== held) begin
            nerr++; $display("FAIL bp_hold cyc%0d: valid=%b res=%h required 1 and %h", cyc, out_valid, out_result, held);
          end
        end
      end
      if (out_valid && !out_ready && !have_held) begin held = out_result; have_held = 1'b1; end
      if (out_valid && out_ready) begin
        got.push_back(out_result);
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (in_valid && in_ready) idx++;
      @(posedge clk);
      if (got.size() == 4) break;
    end
    @(negedge clk); in_valid = 1'b0;
    nchecks++;
    if (got.size() != 4) begin
      nerr++; $display("FAIL bp_count: %0d results required 4", got.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        nchecks++;
        if (got[k] !== k + 1) begin nerr++; $display("FAIL bp_order[%0d]: %h required %h", k, got[k], k + 1); end
      end
      nchecks++;
      if (last - first != 3) begin nerr++; $display("FAIL bp_gap: span %0d cycles required 3", last - first); end
    end
  endtask

  task automatic test_reset_midstall();
    int accepts = 0;
    int seen = 0;
    for (int cyc = 0; cyc < 8 && accepts < 2; cyc++) begin
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1;
      drive(mk(7'b1100011, 3'd4, 1'b0, 32'd0, 32'd1, 32'd0, 32'd0));
      #1;
      if (in_ready) accepts++;
      @(posedge clk);
    end
    @(negedge clk); #1;
    nchecks++;
    if ({out_valid, in_ready, out_branch_taken} !== 3'b101) begin
      nerr++; $display("FAIL rst_full: valid/in_ready/taken=%b required 101", {out_valid, in_ready, out_branch_taken});
    end
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk); reset = 1'b0; in_valid = 1'b0; #1;
    check_idle("rst_midstall");
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk); #1;
      if (out_valid) seen++;
    end
    nchecks++;
    if (seen != 0) begin nerr++; $display("FAIL rst_drop: %0d results after reset required 0", seen); end
  endtask

  function automatic instr_t rand_instr();
    logic [6:0] ops[9];
    instr_t     i;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100111,
            7'b0110111, 7'b0010111, 7'b1100011, 7'b1100011};
    i.op  = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
    i.f3  = 3'($urandom);
    i.f7  = 1'($urandom);
    i.rs1 = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 40)) - 32'd20;
    i.rs2 = ($urandom_range(0, 3) == 0) ? i.rs1 : $urandom;
    i.imm = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 31));
    i.pc  = $urandom;
    return i;
  endfunction

  task automatic test_random();
    exp_t        q[$];
    exp_t        exp_v;
    instr_t      i;
    logic        was_held = 1'b0;
    logic [34:0] held;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      i = rand_instr();
      drive(i);
      #1;
      if (was_held) begin
        nchecks++;
        if (out_valid !== 1'b1 || {out_result, out_is_branch, out_branch_taken} !== held) begin
          nerr++; $display("FAIL rnd_stable cyc%0d: outputs changed while stalled", cyc);
        end
      end
      if (out_valid && out_ready) begin
        nchecks++;
        if (q.size() == 0) begin
          nerr++; $display("FAIL rnd_spurious cyc%0d: result %h with nothing outstanding", cyc, out_result);
        end else begin
          exp_v = q.pop_front();
          if ({out_result, out_is_branch, out_branch_taken, out_illegal} !== exp_v) begin
            nerr++; $display("FAIL rnd_result cyc%0d: res=%h br=%b tk=%b ill=%b required res=%h br=%b tk=%b ill=%b",
                             cyc, out_result, out_is_branch, out_branch_taken, out_illegal,
                             exp_v.res, exp_v.br, exp_v.tk, exp_v.ill);
          end
        end
      end
      was_held = out_valid && !out_ready;
      held     = {out_result, out_is_branch, out_branch_taken};
      if (in_valid && in_ready) q.push_back(model(i));
      @(posedge clk);
    end
    for (int cyc = 0; cyc < 8 && q.size() > 0; cyc++) begin
      @(negedge clk); in_valid = 1'b0; out_ready = 1'b1; #1;
      if (out_valid) begin
        exp_v = q.pop_front();
        nchecks++;
        if ({out_result, out_is_branch, out_branch_taken, out_illegal} !== exp_v) begin
          nerr++; $display("FAIL rnd_drain: res=%h required %h", out_result, exp_v.res);
        end
      end
      @(posedge clk);
    end
    nchecks++;
    if (q.size() != 0) begin nerr++; $display("FAIL rnd_lost: %0d results never emerged", q.size()); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midstall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
